// File: rtl/universal_register.sv
// Universal shift register: preset, parallel load, shift left/right and rotate right,
// with a saturating count of shift/rotate operations since the last reset, preset or load.
module universal_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         c,
    input  logic                         r,
    input  logic                         p,
    input  logic                         l,
    input  logic [WIDTH-1:0]             d,
    input  logic [1:0]                   m,
    input  logic                         sir,
    input  logic                         sil,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             qn,
    output logic                         so,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         full
);

    localparam int            CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_ROR  = 2'b11
    } mode_t;

    mode_t           mode;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic             full_next;
    logic             shifting;

    assign mode = mode_t'(m);

    // Priority is preset, then load, then the shift mode; only shifts advance the count.
    always_comb begin
        q_next   = q;
        cnt_next = cnt;
        shifting = 1'b0;
        if (p) begin
            q_next   = '1;
            cnt_next = '0;
        end else if (l) begin
            q_next   = d;
            cnt_next = '0;
        end else begin
            unique case (mode)
                MODE_HOLD: q_next = q;
                MODE_SHR: begin
                    q_next   = {sir, q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                MODE_SHL: begin
                    q_next   = {q[WIDTH-2:0], sil};
                    shifting = 1'b1;
                end
                MODE_ROR: begin
                    q_next   = {q[0], q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                default: q_next = q;
            endcase
            if (shifting && (cnt != CNT_MAX)) begin
                cnt_next = cnt + CW'(1);
            end
        end
        full_next = (cnt_next == CNT_MAX);
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            q    <= q_next;
            cnt  <= cnt_next;
            full <= full_next;
        end
    end

    assign qn = ~q;

    // Serial out is the bit that is about to leave the register in the current direction.
    always_comb begin
        so = 1'b0;
        unique case (mode)
            MODE_HOLD: so = 1'b0;
            MODE_SHR:  so = q[0];
            MODE_SHL:  so = q[WIDTH-1];
            MODE_ROR:  so = q[0];
            default:   so = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_universal_register.sv
// Directed testbench for universal_register (WIDTH=8, RESET_VAL=0): each task drives one
// scenario and compares outputs against hand-computed values.
module tb_universal_register;

    logic       c;
    logic       r;
    logic       p;
    logic       l;
    logic [7:0] d;
    logic [1:0] m;
    logic       sir;
    logic       sil;
    logic [7:0] q;
    logic [7:0] qn;
    logic       so;
    logic [3:0] cnt;
    logic       full;

    int errors = 0;
    int checks = 0;

    universal_register #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .c   (c),
        .r   (r),
        .p   (p),
        .l   (l),
        .d   (d),
        .m   (m),
        .sir (sir),
        .sil (sil),
        .q   (q),
        .qn  (qn),
        .so  (so),
        .cnt (cnt),
        .full(full)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick;
        @(posedge c);
        #1;
    endtask

    task automatic load_value(input logic [7:0] v);
        p = 1'b0; l = 1'b1; d = v; m = 2'b00;
        tick();
        l = 1'b0;
    endtask

    task automatic test_reset;
        r = 1'b1; p = 1'b0; l = 1'b0; d = 8'h00; m = 2'b00; sir = 1'b0; sil = 1'b0;
        #2;
        checks++; if (q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q got=%h exp=00", q); end
        checks++; if (qn !== 8'hFF) begin errors++; $display("[TB] FAIL reset_qn got=%h exp=FF", qn); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
        checks++; if (so !== 1'b0) begin errors++; $display("[TB] FAIL reset_so got=%b exp=0", so); end
        tick();
        r = 1'b0;
    endtask

    task automatic test_load;
        load_value(8'hA5);
        checks++; if (q !== 8'hA5) begin errors++; $display("[TB] FAIL load_q got=%h exp=A5", q); end
        checks++; if (qn !== 8'h5A) begin errors++; $display("[TB] FAIL load_qn got=%h exp=5A", qn); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("[TB] FAIL load_cnt got=%0d exp=0", cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL load_full got=%b exp=0", full); end
    endtask

    task automatic test_rotate;
        load_value(8'h81);
        m = 2'b11;
        checks++; if (so !== 1'b1) begin errors++; $display("[TB] FAIL rot_so got=%b exp=1", so); end
        for (int i = 1; i <= 7; i++) tick();
        checks++; if (q !== 8'h03) begin errors++; $display("[TB] FAIL rot7_q got=%h exp=03", q); end
        checks++; if (cnt !== 4'd7) begin errors++; $display("[TB] FAIL rot7_cnt got=%0d exp=7", cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL rot7_full got=%b exp=0", full); end
        tick();
        checks++; if (q !== 8'h81) begin errors++; $display("[TB] FAIL rot8_q got=%h exp=81", q); end
        checks++; if (cnt !== 4'd8) begin errors++; $display("[TB] FAIL rot8_cnt got=%0d exp=8", cnt); end
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL rot8_full got=%b exp=1", full); end
        tick();
        checks++; if (q !== 8'hC0) begin errors++; $display("[TB] FAIL rot9_q got=%h exp=C0", q); end
        checks++; if (cnt !== 4'd8) begin errors++; $display("[TB] FAIL rot9_cnt got=%0d exp=8", cnt); end
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL rot9_full got=%b exp=1", full); end
        m = 2'b00;
    endtask

    task automatic test_shift_mix;
        load_value(8'h00);
        m = 2'b01; sir = 1'b1;
        tick(); tick(); tick();
        checks++; if (q !== 8'hE0) begin errors++; $display("[TB] FAIL shr_q got=%h exp=E0", q); end
        checks++; if (cnt !== 4'd3) begin errors++; $display("[TB] FAIL shr_cnt got=%0d exp=3", cnt); end
        checks++; if (so !== 1'b0) begin errors++; $display("[TB] FAIL shr_so got=%b exp=0", so); end
        m = 2'b10; sil = 1'b0; sir = 1'b0;
        #1;
        checks++; if (so !== 1'b1) begin errors++; $display("[TB] FAIL shl_so_pre got=%b exp=1", so); end
        tick();
        checks++; if (q !== 8'hC0) begin errors++; $display("[TB] FAIL shl_q got=%h exp=C0", q); end
        checks++; if (cnt !== 4'd4) begin errors++; $display("[TB] FAIL shl_cnt got=%0d exp=4", cnt); end
        sil = 1'b1;
        tick();
        checks++; if (q !== 8'h81) begin errors++; $display("[TB] FAIL shl_sil_q got=%h exp=81", q); end
        m = 2'b00;
    endtask

    task automatic test_preset;
        load_value(8'h00);
        m = 2'b01; sir = 1'b0;
        tick();
        checks++; if (cnt !== 4'd1) begin errors++; $display("[TB] FAIL pre_setup_cnt got=%0d exp=1", cnt); end
        p = 1'b1; l = 1'b1; d = 8'h00; m = 2'b01;
        tick();
        checks++; if (q !== 8'hFF) begin errors++; $display("[TB] FAIL preset_q got=%h exp=FF", q); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("[TB] FAIL preset_cnt got=%0d exp=0", cnt); end
        p = 1'b0; l = 1'b1; d = 8'h3C;
        tick();
        checks++; if (q !== 8'h3C) begin errors++; $display("[TB] FAIL post_preset_load got=%h exp=3C", q); end
        l = 1'b0; m = 2'b00;
    endtask

    task automatic test_async_reset;
        load_value(8'h5A);
        m = 2'b01; sir = 1'b0;
        tick(); tick();
        checks++; if (q !== 8'h16) begin errors++; $display("[TB] FAIL pre_rst_q got=%h exp=16", q); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("[TB] FAIL pre_rst_cnt got=%0d exp=2", cnt); end
        #2;
        r = 1'b1;
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("[TB] FAIL async_q got=%h exp=00", q); end
        checks++; if (qn !== 8'hFF) begin errors++; $display("[TB] FAIL async_qn got=%h exp=FF", qn); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("[TB] FAIL async_cnt got=%0d exp=0", cnt); end
        l = 1'b1; d = 8'hFF; p = 1'b1;
        tick(); tick();
        checks++; if (q !== 8'h00) begin errors++; $display("[TB] FAIL rst_hold_q got=%h exp=00", q); end
        p = 1'b0;
        r = 1'b0;
        tick();
        checks++; if (q !== 8'hFF) begin errors++; $display("[TB] FAIL post_rst_load got=%h exp=FF", q); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("[TB] FAIL post_rst_cnt got=%0d exp=0", cnt); end
        l = 1'b0; m = 2'b00;
    endtask

    task automatic test_hold;
        load_value(8'h3C);
        m = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (q !== 8'h3C) begin errors++; $display("[TB] FAIL hold_q[%0d] got=%h exp=3C", i, q); end
            checks++; if (cnt !== 4'd0) begin errors++; $display("[TB] FAIL hold_cnt[%0d] got=%0d exp=0", i, cnt); end
            checks++; if (so !== 1'b0) begin errors++; $display("[TB] FAIL hold_so[%0d] got=%b exp=0", i, so); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_rotate();
        test_shift_mix();
        test_preset();
        test_async_reset();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register width in bits; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0, SHALL be the WIDTH-bit value loaded into q on reset.
REQ-003 Port c, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port r, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 Port p, input, 1 bit, SHALL be the synchronous preset: sets all q bits to 1.
REQ-006 Port l, input, 1 bit, SHALL be the synchronous parallel-load enable.
REQ-007 Port d, input, WIDTH bits, SHALL be the parallel-load data.
REQ-008 Port m, input, 2 bits, SHALL select the mode: 00 hold, 01 shift right, 10 shift left, 11 rotate right.
REQ-009 Port sir, input, 1 bit, SHALL be the serial input entering q[WIDTH-1] on a right shift.
REQ-010 Port sil, input, 1 bit, SHALL be the serial input entering q[0] on a left shift.
REQ-011 Port q, output, WIDTH bits, SHALL be the register contents.
REQ-012 Port qn, output, WIDTH bits, SHALL be ~q, combinational.
REQ-013 Port so, output, 1 bit, SHALL be the serial out: q[0] when m=01 or 11, q[WIDTH-1] when m=10, 0 when m=00; combinational.
REQ-014 Port cnt, output, clog2(WIDTH+1) bits, SHALL be the number of shift/rotate operations since the last reset, preset or load, saturating at WIDTH.
REQ-015 Port full, output, 1 bit, SHALL be 1 exactly when cnt==WIDTH; registered with cnt.

Function
REQ-016 Priority per rising edge of c SHALL be p > l > m; exactly one operation per cycle.
REQ-017 p=1 SHALL set q to all ones and cnt to 0, ignoring l, d and m.
REQ-018 p=0, l=1 SHALL set q to d and cnt to 0, ignoring m.
REQ-019 p=0, l=0, m=00 SHALL hold q and cnt.
REQ-020 m=01 SHALL set q to {sir, q[WIDTH-1:1]}.
REQ-021 m=10 SHALL set q to {q[WIDTH-2:0], sil}.
REQ-022 m=11 SHALL set q to {q[0], q[WIDTH-1:1]} and ignore sir/sil.
REQ-023 Each shift or rotate SHALL increment cnt by 1 when cnt<WIDTH; at cnt==WIDTH it SHALL hold (no wrap to 0).
REQ-024 Once full=1, shift/rotate SHALL still update q; only cnt saturates.
REQ-025 A mode change mid-sequence SHALL NOT clear cnt; only reset, preset or load clear it.
REQ-026 Latency: q, cnt and full SHALL reflect an operation one cycle after the sampling edge, with no additional pipeline stage.
REQ-027 After WIDTH consecutive rotates from load value V with no intervening load or preset, q SHALL equal V and full SHALL equal 1.
REQ-028 qn and so SHALL follow q and m combinationally with no added state.

Reset
REQ-029 r=1 SHALL immediately, without a clock edge, force q=RESET_VAL, cnt=0, full=0.
REQ-030 While r=1, all clock edges SHALL be ignored, including p and l.
REQ-031 r asserted mid-sequence SHALL discard the in-progress shift count; the first edge after r falls SHALL execute normally from the reset state.
REQ-032 qn SHALL equal ~RESET_VAL during reset.

Verification (WIDTH=8, RESET_VAL=0)
REQ-033 Reset, then l=1, d=8'hA5, one edge -> q=A5, qn=5A, cnt=0, full=0.
REQ-034 Load 8'h81, then m=11 for 8 edges -> q=81 after edge 8, cnt=8, full=1; a 9th rotate -> q=C0, cnt stays 8.
REQ-035 Load 00, m=01, sir=1 for 3 edges -> q=E0, cnt=3, so=0; switch to m=10, sil=0 for 1 edge -> q=C0, cnt=4.
REQ-036 p=1, l=1, d=00, m=01 on one edge -> q=FF, cnt=0 (preset wins); next edge p=0, l=1, d=3C -> q=3C.
REQ-037 Load 5A, shift 2 edges, assert r between edges without a clock -> q=00, cnt=0 at once; clock edges with r=1 and l=1, d=FF -> q stays 00.
REQ-038 Load 3C, m=00 for 5 edges -> q=3C, cnt=0, so=0 throughout.
